// File: rtl/mips_sc_sequencer.sv
// mips_sc_sequencer
// Run-control sequencer and main/ALU decoder for the single-cycle MIPS datapath.
// Decode is purely combinational; only the run-control FSM, the retired-instruction
// counter and the halt cause are registered. Reset is asynchronous and active-low
// on rst, and forces every output low while asserted.
module mips_sc_sequencer #(
  parameter logic [31:0]      HALT_WORD  = 32'hFC00_0000,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] MAX_RETIRE = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic [31:0]      instruction,
  input  logic             zero,
  output logic [2:0]       ALUoperation,
  output logic             ldinpc,
  output logic             initpc,
  output logic             JumpSrc,
  output logic             PCsignal,
  output logic             RegDst,
  output logic             WriteSrc,
  output logic             RegWSrc,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             PCSrc,
  output logic             MemtoReg,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Halt causes
  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_HALT  = 2'b01;
  localparam logic [1:0] CAUSE_ILLEG = 2'b10;
  localparam logic [1:0] CAUSE_WDOG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_INIT = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] retired_reg;
  logic [CNT_W-1:0] retired_next;
  logic [1:0]       cause_reg;
  logic [1:0]       cause_next;

  logic [5:0] opcode;
  logic [5:0] funct;

  // Raw decode, before run-control gating
  logic [2:0] dec_alu;
  logic       dec_jumpsrc;
  logic       dec_pcsignal;
  logic       dec_regdst;
  logic       dec_writesrc;
  logic       dec_regwsrc;
  logic       dec_regwrite;
  logic       dec_alusrc;
  logic       dec_memread;
  logic       dec_memwrite;
  logic       dec_pcsrc;
  logic       dec_memtoreg;
  logic       dec_legal;

  logic is_halt;
  logic in_run;
  logic go;
  logic commit;
  logic wd_hit;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  // Main and ALU decode: lines default low, each instruction class raises its own.
  always_comb begin
    dec_alu      = ALU_AND;
    dec_jumpsrc  = 1'b0;
    dec_pcsignal = 1'b0;
    dec_regdst   = 1'b0;
    dec_writesrc = 1'b0;
    dec_regwsrc  = 1'b0;
    dec_regwrite = 1'b0;
    dec_alusrc   = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_pcsrc    = 1'b0;
    dec_memtoreg = 1'b0;
    dec_legal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_legal    = 1'b1;
        dec_regdst   = 1'b1;
        dec_regwrite = 1'b1;
        case (funct)
          FN_ADD: dec_alu = ALU_ADD;
          FN_SUB: dec_alu = ALU_SUB;
          FN_AND: dec_alu = ALU_AND;
          FN_OR:  dec_alu = ALU_OR;
          FN_SLT: dec_alu = ALU_SLT;
          FN_JR: begin
            // jr jumps to a register target and writes nothing back
            dec_pcsignal = 1'b1;
            dec_jumpsrc  = 1'b0;
            dec_regwrite = 1'b0;
          end
          default: begin
            // Unknown funct: report illegal and drive nothing
            dec_legal    = 1'b0;
            dec_regdst   = 1'b0;
            dec_regwrite = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        dec_legal    = 1'b1;
        dec_alusrc   = 1'b1;
        dec_alu      = ALU_ADD;
        dec_regwrite = 1'b1;
      end
      OP_SLTI: begin
        dec_legal    = 1'b1;
        dec_alusrc   = 1'b1;
        dec_alu      = ALU_SLT;
        dec_regwrite = 1'b1;
      end
      OP_LW: begin
        dec_legal    = 1'b1;
        dec_alusrc   = 1'b1;
        dec_alu      = ALU_ADD;
        dec_memread  = 1'b1;
        dec_memtoreg = 1'b1;
        dec_regwrite = 1'b1;
      end
      OP_SW: begin
        dec_legal    = 1'b1;
        dec_alusrc   = 1'b1;
        dec_alu      = ALU_ADD;
        dec_memwrite = 1'b1;
      end
      OP_BEQ: begin
        dec_legal = 1'b1;
        dec_alu   = ALU_SUB;
        dec_pcsrc = zero;
      end
      OP_J: begin
        dec_legal    = 1'b1;
        dec_pcsignal = 1'b1;
        dec_jumpsrc  = 1'b1;
      end
      OP_JAL: begin
        // jal links the return address into the link register
        dec_legal    = 1'b1;
        dec_pcsignal = 1'b1;
        dec_jumpsrc  = 1'b1;
        dec_regwsrc  = 1'b1;
        dec_writesrc = 1'b1;
        dec_regwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // The halt word shares no encoding with a legal instruction, so it is
  // matched on the full word and kept separate from the illegal-decode path.
  assign is_halt = (instruction == HALT_WORD);
  assign in_run  = (state_reg == ST_RUN);
  assign go      = !step_mode || step;
  assign commit  = in_run && go && dec_legal && !is_halt;
  assign wd_hit  = commit && (retired_reg == (MAX_RETIRE - 1'b1));

  // Run-control state, retired counter and halt cause registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      retired_reg <= '0;
      cause_reg   <= CAUSE_NONE;
    end else begin
      state_reg   <= state_next;
      retired_reg <= retired_next;
      cause_reg   <= cause_next;
    end
  end

  // Next-state logic: halt conditions take priority over commit; start only acts when stopped.
  always_comb begin
    state_next   = state_reg;
    retired_next = retired_reg;
    cause_next   = cause_reg;
    case (state_reg)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_next = ST_INIT;
        end
      end
      ST_INIT: begin
        state_next   = ST_RUN;
        retired_next = '0;
        cause_next   = CAUSE_NONE;
      end
      ST_RUN: begin
        if (is_halt) begin
          state_next = ST_HALT;
          cause_next = CAUSE_HALT;
        end else if (!dec_legal) begin
          state_next = ST_HALT;
          cause_next = CAUSE_ILLEG;
        end else if (commit) begin
          retired_next = retired_reg + 1'b1;
          if (wd_hit) begin
            state_next = ST_HALT;
            cause_next = CAUSE_WDOG;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output drive: architectural writes only on commit, everything low while in reset.
  always_comb begin
    ALUoperation = 3'b000;
    ldinpc       = 1'b0;
    initpc       = 1'b0;
    JumpSrc      = 1'b0;
    PCsignal     = 1'b0;
    RegDst       = 1'b0;
    WriteSrc     = 1'b0;
    RegWSrc      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrc       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    PCSrc        = 1'b0;
    MemtoReg     = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    halt_cause   = CAUSE_NONE;
    retired      = '0;
    if (rst) begin
      ALUoperation = dec_alu;
      JumpSrc      = dec_jumpsrc;
      PCsignal     = dec_pcsignal;
      RegDst       = dec_regdst;
      WriteSrc     = dec_writesrc;
      RegWSrc      = dec_regwsrc;
      ALUSrc       = dec_alusrc;
      PCSrc        = dec_pcsrc;
      MemtoReg     = dec_memtoreg;
      RegWrite     = dec_regwrite && commit;
      MemWrite     = dec_memwrite && commit;
      MemRead      = dec_memread && in_run;
      ldinpc       = commit;
      initpc       = (state_reg == ST_INIT);
      busy         = (state_reg == ST_INIT) || in_run;
      halted       = (state_reg == ST_HALT);
      halt_cause   = cause_reg;
      retired      = retired_reg;
    end
  end

endmodule

// File: tb/tb_mips_sc_sequencer.sv
// tb_mips_sc_sequencer
// Self-checking bench: reset, decode table, hand sequences for run control,
// watchdog (second instance with a small limit) and randomized stimulus
// checked against a behavioural reference model.
module tb_mips_sc_sequencer;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        step_mode;
  logic        step;
  logic [31:0] instruction;
  logic        zero;

  logic [2:0]  ALUoperation;
  logic        ldinpc, initpc, JumpSrc, PCsignal, RegDst, WriteSrc, RegWSrc;
  logic        RegWrite, ALUSrc, MemRead, MemWrite, PCSrc, MemtoReg;
  logic        busy, halted;
  logic [1:0]  halt_cause;
  logic [15:0] retired;

  logic [2:0]  w_alu;
  logic        w_ldinpc, w_initpc, w_jumpsrc, w_pcsignal, w_regdst, w_writesrc, w_regwsrc;
  logic        w_regwrite, w_alusrc, w_memread, w_memwrite, w_pcsrc, w_memtoreg;
  logic        w_busy, w_halted;
  logic [1:0]  w_cause;
  logic [15:0] w_retired;

  always #5 clk = ~clk;

  mips_sc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .instruction(instruction), .zero(zero),
    .ALUoperation(ALUoperation), .ldinpc(ldinpc), .initpc(initpc),
    .JumpSrc(JumpSrc), .PCsignal(PCsignal), .RegDst(RegDst), .WriteSrc(WriteSrc),
    .RegWSrc(RegWSrc), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .PCSrc(PCSrc), .MemtoReg(MemtoReg),
    .busy(busy), .halted(halted), .halt_cause(halt_cause), .retired(retired)
  );

  mips_sc_sequencer #(.MAX_RETIRE(16'd3)) dut_wd (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .instruction(instruction), .zero(zero),
    .ALUoperation(w_alu), .ldinpc(w_ldinpc), .initpc(w_initpc),
    .JumpSrc(w_jumpsrc), .PCsignal(w_pcsignal), .RegDst(w_regdst), .WriteSrc(w_writesrc),
    .RegWSrc(w_regwsrc), .RegWrite(w_regwrite), .ALUSrc(w_alusrc), .MemRead(w_memread),
    .MemWrite(w_memwrite), .PCSrc(w_pcsrc), .MemtoReg(w_memtoreg),
    .busy(w_busy), .halted(w_halted), .halt_cause(w_cause), .retired(w_retired)
  );

  typedef struct packed {
    logic [2:0] alu;
    logic jumpsrc, pcsignal, regdst, writesrc, regwsrc, regwrite;
    logic alusrc, memread, memwrite, pcsrc, memtoreg, ldinpc, initpc;
  } ctl_t;

  ctl_t act_ctl;
  assign act_ctl = {ALUoperation, JumpSrc, PCsignal, RegDst, WriteSrc, RegWSrc, RegWrite,
                    ALUSrc, MemRead, MemWrite, PCSrc, MemtoReg, ldinpc, initpc};

  // Decode table record; lines = JumpSrc PCsignal RegDst WriteSrc RegWSrc RegWrite
  // ALUSrc MemRead MemWrite PCSrc MemtoReg
  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        z;
    logic [2:0]  alu;
    logic [10:0] lines;
  } vec_t;

  vec_t vt[14];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model of run control
  bit          m_init, m_run, m_halt;
  logic [15:0] m_cnt;
  logic [1:0]  m_cause;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] fn);
    return {6'd0, 5'd9, 5'd10, 5'd11, 5'd0, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op);
    return {op, 5'd4, 5'd5, 16'h0010};
  endfunction

  // Name the instruction from its opcode/funct fields
  function automatic string mnem(input logic [31:0] ins);
    if (ins == HALT_W) return "halt";
    case (ins[31:26])
      6'd0: begin
        case (ins[5:0])
          6'd32: return "add";
          6'd34: return "sub";
          6'd36: return "and";
          6'd37: return "or";
          6'd42: return "slt";
          6'd8:  return "jr";
          default: return "ill";
        endcase
      end
      6'd8:  return "addi";
      6'd10: return "slti";
      6'd35: return "lw";
      6'd43: return "sw";
      6'd4:  return "beq";
      6'd2:  return "j";
      6'd3:  return "jal";
      default: return "ill";
    endcase
  endfunction

  // Ungated control lines for a mnemonic, written line by line from the decode rules
  function automatic ctl_t spec_ctl(input string m, input logic z);
    ctl_t c;
    bit rtype;
    c = '0;
    rtype = (m == "add") || (m == "sub") || (m == "and") || (m == "or") ||
            (m == "slt") || (m == "jr");
    if (m == "add" || m == "addi" || m == "lw" || m == "sw") c.alu = 3'b010;
    else if (m == "sub" || m == "beq") c.alu = 3'b110;
    else if (m == "or") c.alu = 3'b001;
    else if (m == "slt" || m == "slti") c.alu = 3'b111;
    c.regdst   = rtype;
    c.regwrite = (rtype && m != "jr") || m == "addi" || m == "slti" || m == "lw" || m == "jal";
    c.alusrc   = (m == "addi") || (m == "slti") || (m == "lw") || (m == "sw");
    c.memread  = (m == "lw");
    c.memtoreg = (m == "lw");
    c.memwrite = (m == "sw");
    c.pcsrc    = (m == "beq") && z;
    c.pcsignal = (m == "jr") || (m == "j") || (m == "jal");
    c.jumpsrc  = (m == "j") || (m == "jal");
    c.regwsrc  = (m == "jal");
    c.writesrc = (m == "jal");
    return c;
  endfunction

  // One clock: drive inputs, compare against the model, advance the model at the edge
  task automatic tick(input logic [31:0] ins, input logic z, input logic sm,
                      input logic stp, input logic st);
    string m;
    ctl_t  exp, mask;
    bit    legal, commit;
    instruction = ins; zero = z; step_mode = sm; step = stp; start = st;
    #3;
    m      = mnem(ins);
    legal  = (m != "ill") && (m != "halt");
    commit = m_run && (!sm || stp) && legal;
    exp    = (legal && m_run) ? spec_ctl(m, z) : spec_ctl(legal ? m : "none", z);
    if (!commit) begin exp.regwrite = 1'b0; exp.memwrite = 1'b0; end
    if (!m_run) exp.memread = 1'b0;
    exp.ldinpc = commit;
    exp.initpc = m_init;
    if (m_run) mask = '1;
    else begin
      mask = '0;
      mask.regwrite = 1'b1; mask.memwrite = 1'b1; mask.memread = 1'b1;
      mask.ldinpc = 1'b1; mask.initpc = 1'b1;
    end
    check("ctl", 64'(act_ctl & mask), 64'(exp & mask));
    check("status", {44'd0, busy, halted, halt_cause, retired},
          {44'd0, m_init | m_run, m_halt, m_cause, m_cnt});
    @(posedge clk);
    if (m_init) begin
      m_init = 1'b0; m_run = 1'b1; m_cnt = '0; m_cause = 2'd0;
    end else if (m_run) begin
      if (m == "halt") begin
        m_run = 1'b0; m_halt = 1'b1; m_cause = 2'd1;
      end else if (!legal) begin
        m_run = 1'b0; m_halt = 1'b1; m_cause = 2'd2;
      end else if (commit) begin
        m_cnt = m_cnt + 16'd1;
        if (m_cnt == 16'hFFFF) begin
          m_run = 1'b0; m_halt = 1'b1; m_cause = 2'd3;
        end
      end
    end else if (st) begin
      m_init = 1'b1; m_halt = 1'b0;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 12))
      0:  return {6'd0, r[25:6], 6'd32};
      1:  return {6'd0, r[25:6], 6'd34};
      2:  return {6'd0, r[25:6], 6'd36};
      3:  return {6'd0, r[25:6], 6'd37};
      4:  return {6'd0, r[25:6], 6'd42};
      5:  return {6'd0, r[25:6], 6'd8};
      6:  return {6'd8,  r[25:0]};
      7:  return {6'd10, r[25:0]};
      8:  return {6'd35, r[25:0]};
      9:  return {6'd43, r[25:0]};
      10: return {6'd4,  r[25:0]};
      11: return {6'd2,  r[25:0]};
      default: return {6'd3, r[25:0]};
    endcase
  endfunction

  initial begin
    logic [31:0] ins;
    logic        sm, st;
    ctl_t        texp;

    vt[0]  = '{"add",  mk_r(6'd32), 1'b0, 3'b010, 11'b00100100000};
    vt[1]  = '{"sub",  mk_r(6'd34), 1'b0, 3'b110, 11'b00100100000};
    vt[2]  = '{"and",  mk_r(6'd36), 1'b1, 3'b000, 11'b00100100000};
    vt[3]  = '{"or",   mk_r(6'd37), 1'b0, 3'b001, 11'b00100100000};
    vt[4]  = '{"slt",  mk_r(6'd42), 1'b0, 3'b111, 11'b00100100000};
    vt[5]  = '{"jr",   mk_r(6'd8),  1'b0, 3'b000, 11'b01100000000};
    vt[6]  = '{"addi", mk_i(6'd8),  1'b0, 3'b010, 11'b00000110000};
    vt[7]  = '{"slti", mk_i(6'd10), 1'b0, 3'b111, 11'b00000110000};
    vt[8]  = '{"lw",   mk_i(6'd35), 1'b0, 3'b010, 11'b00000111001};
    vt[9]  = '{"sw",   mk_i(6'd43), 1'b0, 3'b010, 11'b00000010100};
    vt[10] = '{"beq1", mk_i(6'd4),  1'b1, 3'b110, 11'b00000000010};
    vt[11] = '{"beq0", mk_i(6'd4),  1'b0, 3'b110, 11'b00000000000};
    vt[12] = '{"j",    mk_i(6'd2),  1'b0, 3'b000, 11'b11000000000};
    vt[13] = '{"jal",  mk_i(6'd3),  1'b0, 3'b000, 11'b11011100000};

    // Reset: everything low even with a store on the instruction bus
    rst = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; zero = 1'b0;
    instruction = mk_i(6'd43);
    m_init = 1'b0; m_run = 1'b0; m_halt = 1'b0; m_cnt = '0; m_cause = 2'd0;
    #2;
    check("reset_ctl", 64'(act_ctl), 64'd0);
    check("reset_status", {busy, halted, halt_cause, retired}, 20'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Start, one INIT cycle, then add/addi/lw/sw
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b1);
    check("init_pulse", initpc, 1'b1);
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b0);
    tick(mk_r(6'd32), 1'b0, 1'b0, 1'b0, 1'b0);
    tick(mk_i(6'd8),  1'b0, 1'b0, 1'b0, 1'b0);
    tick(mk_i(6'd35), 1'b0, 1'b0, 1'b0, 1'b0);
    tick(mk_i(6'd43), 1'b0, 1'b0, 1'b0, 1'b0);
    check("seq_retired", retired, 16'd4);

    // Single step: five idle cycles, one pulse, then step held for two cycles
    for (int i = 0; i < 5; i++) tick(mk_i(6'd8), 1'b0, 1'b1, 1'b0, 1'b0);
    check("step_hold_retired", retired, 16'd4);
    tick(mk_i(6'd8), 1'b0, 1'b1, 1'b1, 1'b0);
    check("step_pulse_retired", retired, 16'd5);
    tick(mk_i(6'd8), 1'b0, 1'b1, 1'b1, 1'b0);
    tick(mk_i(6'd8), 1'b0, 1'b1, 1'b1, 1'b0);
    check("step_held_retired", retired, 16'd7);

    // Decode table in free-run
    for (int i = 0; i < 14; i++) begin
      instruction = vt[i].ins; zero = vt[i].z; step_mode = 1'b0; step = 1'b0; start = 1'b0;
      #2;
      texp = {vt[i].alu, vt[i].lines, 1'b1, 1'b0};
      check({"dec_", vt[i].name}, 64'(act_ctl), 64'(texp));
      tick(vt[i].ins, vt[i].z, 1'b0, 1'b0, 1'b0);
    end
    check("table_retired", retired, 16'd21);

    // Halt word with a simultaneous start: halt wins, nothing retired
    instruction = HALT_W; start = 1'b1; #2;
    check("halt_no_ldinpc", ldinpc, 1'b0);
    tick(HALT_W, 1'b0, 1'b0, 1'b0, 1'b1);
    check("halt_state", {halted, busy, halt_cause, retired}, {1'b1, 1'b0, 2'd1, 16'd21});

    // Restart, then an illegal opcode
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b1);
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_retired", retired, 16'd0);
    tick({6'b111110, 26'd0}, 1'b0, 1'b0, 1'b0, 1'b0);
    check("illegal_state", {halted, halt_cause, retired}, {1'b1, 2'd2, 16'd0});

    // Reset asserted mid-RUN while a store is decoded
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b1);
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b0);
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b0);
    instruction = mk_i(6'd43); start = 1'b0;
    #2;
    check("sw_before_reset", MemWrite, 1'b1);
    rst = 1'b0;
    #1;
    check("reset_memwrite", MemWrite, 1'b0);
    check("reset_midrun", {busy, ldinpc, retired}, {1'b0, 1'b0, 16'd0});
    @(posedge clk); #1;
    rst = 1'b1;
    m_init = 1'b0; m_run = 1'b0; m_halt = 1'b0; m_cnt = '0; m_cause = 2'd0;
    tick(mk_i(6'd43), 1'b0, 1'b0, 1'b0, 1'b0);
    check("after_reset_idle", {busy, halted, retired}, {1'b0, 1'b0, 16'd0});

    // Watchdog on the small-limit instance
    tick(HALT_W, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b1);
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b0);
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b0);
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b0);
    check("wd_two", {w_busy, w_retired}, {1'b1, 16'd2});
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b0);
    check("wd_timeout", {w_halted, w_busy, w_cause, w_retired}, {1'b1, 1'b0, 2'd3, 16'd3});
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b0);
    check("wd_frozen", w_retired, 16'd3);
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b1);
    tick(mk_i(6'd8), 1'b0, 1'b0, 1'b0, 1'b0);
    check("wd_restart", {w_busy, w_halted, w_cause, w_retired}, {1'b1, 1'b0, 2'd0, 16'd0});

    // Randomized run against the reference model
    sm = 1'b0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 99)) inside
        [0:3]: ins = HALT_W;
        [4:5]: ins = {6'd0, 20'($urandom), 6'h3F};
        [6:8]: begin
          ins = $urandom;
          while (mnem(ins) != "ill") ins = $urandom;
        end
        default: ins = rand_legal();
      endcase
      if ($urandom_range(0, 19) == 0) sm = ~sm;
      st = (!m_run && !m_init) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
      tick(ins, 1'($urandom), sm, 1'($urandom), st);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
